// File: rtl/time_set_loader_if.sv
// Load channel from the time-set loader to the clock counter: converted 24-hour time
// presented over a valid/ready handshake.
interface time_set_loader_if;
  logic       load_valid;
  logic       load_ready;
  logic [6:0] hrs24;
  logic [6:0] min;

  modport master (
    output load_valid,
    output hrs24,
    output min,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  hrs24,
    input  min,
    output load_ready
  );
endinterface

// File: rtl/time_set_loader.sv
// Captures a 12-hour switch-bank time on a SET edge, range-checks it, converts it to 24-hour
// format and hands it to the counter load port; bad entries raise a sticky error instead.
module time_set_loader #(
  parameter int unsigned cntr_tc_p = 11,
  parameter int unsigned min_tc_p  = 59
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      set_req_i,
  input  logic [6:0]                hrs_disp_i,
  input  logic                      pm_i,
  input  logic [6:0]                min_i,
  output logic                      busy_o,
  output logic                      err_o,
  time_set_loader_if.master         ld
);

  localparam logic [6:0] HrsMax = 7'(cntr_tc_p + 1);
  localparam logic [6:0] MinMax = 7'(min_tc_p);

  typedef enum logic [1:0] {StIdle, StCheck, StLoad, StErr} state_e;

  state_e     state_q, state_d;
  logic       set_req_q;
  logic       req_p;
  logic [6:0] hrs_q, min_cap_q;
  logic       pm_q;
  logic [6:0] hrs24_q, min_q;
  logic [6:0] hrs24_d;
  logic       err_q;
  logic       in_range;

  assign req_p    = set_req_i & ~set_req_q;
  assign in_range = (hrs_q != 7'd0) && (hrs_q <= HrsMax) && (min_cap_q <= MinMax);

  // 12 AM maps to hour 0, 12 PM stays 12; other PM hours shift up by 12.
  always_comb begin
    hrs24_d = hrs_q;
    if (hrs_q == HrsMax) begin
      hrs24_d = pm_q ? HrsMax : 7'd0;
    end else if (pm_q) begin
      hrs24_d = hrs_q + HrsMax;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (req_p) state_d = StCheck;
      StCheck: state_d = in_range ? StLoad : StErr;
      StLoad:  if (ld.load_ready) state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ld.load_valid = 1'b0;
    busy_o        = 1'b1;
    unique case (state_q)
      StIdle:  busy_o = 1'b0;
      StCheck: ;
      StLoad:  ld.load_valid = 1'b1;
      StErr:   ;
      default: busy_o = 1'b0;
    endcase
  end

  // Holding registers decouple the in-flight request from later switch changes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      set_req_q <= 1'b0;
      hrs_q     <= 7'd0;
      pm_q      <= 1'b0;
      min_cap_q <= 7'd0;
      hrs24_q   <= 7'd0;
      min_q     <= 7'd0;
      err_q     <= 1'b0;
    end else begin
      set_req_q <= set_req_i;
      if (state_q == StIdle && req_p) begin
        hrs_q     <= hrs_disp_i;
        pm_q      <= pm_i;
        min_cap_q <= min_i;
      end
      if (state_q == StCheck && in_range) begin
        hrs24_q <= hrs24_d;
        min_q   <= min_cap_q;
        err_q   <= 1'b0;
      end
      if (state_q == StErr) begin
        err_q <= 1'b1;
      end
    end
  end

  assign ld.hrs24 = hrs24_q;
  assign ld.min   = min_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_time_set_loader.sv
// Scoreboard bench for time_set_loader: expected 24-hour loads are queued when a request is
// driven and compared when the DUT completes a valid/ready transfer.
module tb_time_set_loader;

  logic       clk;
  logic       reset;
  logic       set_req;
  logic [6:0] hrs_disp;
  logic       pm;
  logic [6:0] min_sw;
  logic       busy;
  logic       err;

  time_set_loader_if ld_if ();

  time_set_loader dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .set_req_i  (set_req),
    .hrs_disp_i (hrs_disp),
    .pm_i       (pm),
    .min_i      (min_sw),
    .busy_o     (busy),
    .err_o      (err),
    .ld         (ld_if.master)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_xfer = 0;
  logic [13:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Transfer monitor: a handshake seen here completes on the following rising edge.
  always @(negedge clk) begin
    if (!reset && ld_if.load_valid && ld_if.load_ready) begin
      check("sb_nonempty_at_xfer", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        logic [13:0] e;
        e = sb.pop_front();
        check("xfer_hrs24", 32'(ld_if.hrs24), 32'(e[13:7]));
        check("xfer_min", 32'(ld_if.min), 32'(e[6:0]));
        n_xfer++;
      end
    end
  end

  // Drives a one-cycle SET pulse; returns at the negedge after the capturing edge.
  task automatic req(input int h, input int p, input int m);
    @(negedge clk);
    hrs_disp = 7'(h);
    pm       = p[0];
    min_sw   = 7'(m);
    set_req  = 1'b1;
    @(negedge clk);
    set_req  = 1'b0;
  endtask

  function automatic logic [6:0] ref_hrs24(input int h, input int p);
    if (h == 12) return (p != 0) ? 7'd12 : 7'd0;
    return (p != 0) ? 7'(h + 12) : 7'(h);
  endfunction

  int conv_tab[5][3] = '{'{12, 1, 12}, '{7, 1, 19}, '{7, 0, 7}, '{1, 0, 1}, '{11, 1, 23}};
  int bad_tab[3][3]  = '{'{0, 0, 10}, '{13, 0, 10}, '{5, 1, 60}};

  initial begin
    reset = 1'b1; set_req = 1'b0; hrs_disp = '0; pm = 1'b0; min_sw = '0;
    ld_if.load_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_valid", 32'(ld_if.load_valid), 32'd0);
    check("rst_hrs24", 32'(ld_if.hrs24), 32'd0);
    check("rst_min", 32'(ld_if.min), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // 12 AM with ready high: valid for exactly one cycle after the check cycle.
    sb.push_back({7'd0, 7'd30});
    req(12, 0, 30);
    check("lat_busy_check", 32'(busy), 32'd1);
    check("lat_valid_check", 32'(ld_if.load_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_load", 32'(ld_if.load_valid), 32'd1);
    @(negedge clk);
    check("lat_valid_done", 32'(ld_if.load_valid), 32'd0);
    check("lat_busy_done", 32'(busy), 32'd0);

    for (int i = 0; i < 5; i++) begin
      sb.push_back({ref_hrs24(conv_tab[i][0], conv_tab[i][1]), 7'(conv_tab[i][2])});
      req(conv_tab[i][0], conv_tab[i][1], conv_tab[i][2]);
      repeat (3) @(negedge clk);
    end

    // Out-of-range entries: sticky error, no transfer; a good entry clears it.
    for (int i = 0; i < 3; i++) begin
      req(bad_tab[i][0], bad_tab[i][1], bad_tab[i][2]);
      @(negedge clk);
      check("bad_no_valid", 32'(ld_if.load_valid), 32'd0);
      @(negedge clk);
      check("bad_err_set", 32'(err), 32'd1);
      check("bad_idle", 32'(busy), 32'd0);
      sb.push_back({ref_hrs24(4, 0), 7'd0});
      req(4, 0, 0);
      @(negedge clk);
      check("err_cleared", 32'(err), 32'd0);
      repeat (2) @(negedge clk);
    end

    // Backpressure with switch changes and a second SET edge while loading.
    ld_if.load_ready = 1'b0;
    sb.push_back({7'd15, 7'd45});
    req(3, 1, 45);
    @(negedge clk);
    hrs_disp = 7'd9; pm = 1'b0; min_sw = 7'd2;
    for (int i = 0; i < 5; i++) begin
      set_req = (i == 1);
      check("bp_valid", 32'(ld_if.load_valid), 32'd1);
      check("bp_hrs24", 32'(ld_if.hrs24), 32'd15);
      check("bp_min", 32'(ld_if.min), 32'd45);
      if (i < 4) @(negedge clk);
    end
    set_req = 1'b0;
    ld_if.load_ready = 1'b1;
    @(negedge clk);
    check("bp_done_valid", 32'(ld_if.load_valid), 32'd0);
    repeat (4) @(negedge clk);
    check("bp_single_xfer_idle", 32'(busy), 32'd0);
    check("bp_xfer_count", 32'(n_xfer), 32'd10);

    // Reset while in LOAD drops the pending transfer.
    req(8, 0, 1);
    ld_if.load_ready = 1'b0;
    req(2, 0, 17);
    @(negedge clk);
    check("rl_valid_before", 32'(ld_if.load_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rl_valid", 32'(ld_if.load_valid), 32'd0);
    check("rl_busy", 32'(busy), 32'd0);
    check("rl_err", 32'(err), 32'd0);
    check("rl_hrs24", 32'(ld_if.hrs24), 32'd0);
    sb.delete();
    ld_if.load_ready = 1'b1;

    // SET held high through reset yields a request on the first post-reset cycle.
    hrs_disp = 7'd2; pm = 1'b1; min_sw = 7'd5;
    set_req = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.push_back({7'd14, 7'd5});
    check("rs_idle_after_reset", 32'(busy), 32'd0);
    @(negedge clk);
    check("rs_busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    check("rs_no_retrigger", 32'(busy), 32'd0);
    set_req = 1'b0;
    repeat (2) @(negedge clk);

    check("sb_drained", 32'(sb.size()), 32'd0);
    check("xfer_total", 32'(n_xfer), 32'd11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
